// File: rtl/window_reader.sv
// rtl/window_reader.sv - 3x3 sliding window generator over a raster pixel stream with two line memories.
// Optional centre-coordinate outputs are enabled by defining WINDOW_READER_COORD_EN.
module window_reader #(
   parameter int PIXEL_DEPTH = 8,
   parameter int WIDTH       = 8,
   parameter int HEIGHT      = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic                     in_sof,
   input  logic [PIXEL_DEPTH-1:0]   in_pixel,
   output logic                     out_valid,
   output logic [9*PIXEL_DEPTH-1:0] out_window,
`ifdef WINDOW_READER_COORD_EN
   output logic [$clog2(WIDTH)-1:0]  out_x,
   output logic [$clog2(HEIGHT)-1:0] out_y,
`endif
   output logic                     frame_done
);

   localparam int XW = $clog2(WIDTH);
   localparam int YW = $clog2(HEIGHT);

   logic [PIXEL_DEPTH-1:0] line0 [WIDTH];
   logic [PIXEL_DEPTH-1:0] line1 [WIDTH];
   logic [PIXEL_DEPTH-1:0] taps  [3][3];

   logic [XW-1:0]          x_q, cur_x, nxt_x;
   logic [YW-1:0]          y_q, cur_y, nxt_y;
   logic [PIXEL_DEPTH-1:0] rd0, rd1;
   logic                   last_x, last_y, emit;

   // Start-of-frame overrides the counters for the pixel that carries it.
   always_comb begin
      cur_x  = in_sof ? '0 : x_q;
      cur_y  = in_sof ? '0 : y_q;
      rd0    = line0[cur_x];
      rd1    = line1[cur_x];
      last_x = (cur_x == XW'(WIDTH - 1));
      last_y = (cur_y == YW'(HEIGHT - 1));
      emit   = (cur_x >= XW'(2)) && (cur_y >= YW'(2));
      nxt_x  = last_x ? '0 : cur_x + XW'(1);
      nxt_y  = cur_y;
      if (last_x) begin
         nxt_y = last_y ? '0 : cur_y + YW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && in_valid) begin
         line1[cur_x] <= rd0;
         line0[cur_x] <= in_pixel;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q        <= '0;
         y_q        <= '0;
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               taps[r][c] <= '0;
            end
         end
      end else begin
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
         if (in_valid) begin
            x_q        <= nxt_x;
            y_q        <= nxt_y;
            out_valid  <= emit;
            frame_done <= last_x && last_y;
            for (int r = 0; r < 3; r++) begin
               taps[r][0] <= taps[r][1];
               taps[r][1] <= taps[r][2];
            end
            taps[0][2] <= rd1;
            taps[1][2] <= rd0;
            taps[2][2] <= in_pixel;
         end
      end
   end

   always_comb begin
      out_window = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            out_window[(r*3+c)*PIXEL_DEPTH +: PIXEL_DEPTH] = taps[r][c];
         end
      end
   end

`ifdef WINDOW_READER_COORD_EN
   // Centre is one column and one row behind the newest pixel.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_x <= '0;
         out_y <= '0;
      end else if (in_valid && emit) begin
         out_x <= cur_x - XW'(1);
         out_y <= cur_y - YW'(1);
      end
   end
`endif

endmodule

// File: tb/tb_window_reader.sv
// tb/tb_window_reader.sv - randomized bench for window_reader against a frame-image reference model.
module tb_window_reader;
   localparam int PD = 8;
   localparam int W  = 8;
   localparam int H  = 8;

   logic          clk = 1'b0;
   logic          rst, in_valid, in_sof;
   logic [PD-1:0] in_pixel;
   logic          out_valid, frame_done;
   logic [9*PD-1:0] out_window;
`ifdef WINDOW_READER_COORD_EN
   logic [2:0]    out_x, out_y;
`endif

   always #5 clk = ~clk;

   window_reader #(.PIXEL_DEPTH(PD), .WIDTH(W), .HEIGHT(H)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel),
      .out_valid(out_valid), .out_window(out_window),
`ifdef WINDOW_READER_COORD_EN
      .out_x(out_x), .out_y(out_y),
`endif
      .frame_done(frame_done)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Reference model: the current frame as a 2D image plus raster position.
   int           mx = 0, my = 0;
   logic [7:0]   img [H][W];
   int           win_cnt, done_cnt, accepts, first_at;
   bit           got_first;
   logic [71:0]  first_win, last_done_win;

   task automatic clear_stats();
      win_cnt = 0; done_cnt = 0; accepts = 0; first_at = -1;
      got_first = 0; first_win = '0; last_done_win = '0;
   endtask

   function automatic logic [71:0] ramp_win(input int base, input int x0, input int y0);
      logic [71:0] w;
      w = '0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            w[(i*3+j)*8 +: 8] = 8'(base + (y0+i)*W + x0 + j);
      return w;
   endfunction

   task automatic step(input logic rs, input logic v, input logic s, input logic [7:0] p);
      logic ev, ed;
      logic [71:0] ew;
      int cx, cy, ex, ey;
      @(negedge clk);
      rst = rs; in_valid = v; in_sof = s; in_pixel = p;
      @(posedge clk);
      ev = 0; ed = 0; ew = '0; ex = 0; ey = 0;
      if (rs) begin
         mx = 0; my = 0;
      end else if (v) begin
         cx = s ? 0 : mx;
         cy = s ? 0 : my;
         img[cy][cx] = p;
         accepts++;
         if (cx >= 2 && cy >= 2) begin
            ev = 1; ex = cx - 1; ey = cy - 1;
            for (int i = 0; i < 3; i++)
               for (int j = 0; j < 3; j++)
                  ew[(i*3+j)*8 +: 8] = img[cy-2+i][cx-2+j];
         end
         ed = (cx == W-1) && (cy == H-1);
         mx = (cx == W-1) ? 0 : cx + 1;
         my = (cx == W-1) ? ((cy == H-1) ? 0 : cy + 1) : cy;
      end
      #1;
      check("out_valid", 72'(out_valid), 72'(ev));
      check("frame_done", 72'(frame_done), 72'(ed));
      if (rs) check("rst_window", out_window, '0);
      if (ev) begin
         check("window", out_window, ew);
`ifdef WINDOW_READER_COORD_EN
         check("out_x", 72'(out_x), 72'(ex));
         check("out_y", 72'(out_y), 72'(ey));
`endif
      end
      if (out_valid) begin
         win_cnt++;
         if (!got_first) begin
            got_first = 1; first_win = out_window; first_at = accepts;
         end
         if (frame_done) last_done_win = out_window;
      end
      if (frame_done) done_cnt++;
   endtask

   task automatic maybe_gap(input bit gaps);
      if (gaps && $urandom_range(0, 2) == 0)
         repeat ($urandom_range(1, 5)) step(0, 0, 0, 8'($urandom));
   endtask

   // base < 0 selects random pixel values.
   task automatic send_frame(input int base, input bit gaps, input bit sof_first);
      for (int yy = 0; yy < H; yy++)
         for (int xx = 0; xx < W; xx++) begin
            maybe_gap(gaps);
            step(0, 1, sof_first && xx == 0 && yy == 0,
                 (base < 0) ? 8'($urandom) : 8'(base + yy*W + xx));
         end
   endtask

   initial begin
      rst = 1; in_valid = 0; in_sof = 0; in_pixel = '0;
      clear_stats();
      step(1, 1, 0, 8'hff);
      step(0, 0, 0, 8'h00);

      // Continuous ramp frame.
      clear_stats();
      send_frame(0, 0, 1);
      step(0, 0, 0, 0);
      check("a_count", 72'(win_cnt), 72'(36));
      check("a_first", first_win, ramp_win(0, 0, 0));
      check("a_last", last_done_win, ramp_win(0, 5, 5));
      check("a_done", 72'(done_cnt), 72'(1));

      // Same frame with random idle gaps.
      clear_stats();
      send_frame(0, 1, 1);
      check("b_count", 72'(win_cnt), 72'(36));
      check("b_first", first_win, ramp_win(0, 0, 0));
      check("b_last", last_done_win, ramp_win(0, 5, 5));

      // Back-to-back frames.
      clear_stats();
      send_frame(0, 0, 1);
      clear_stats();
      send_frame(64, 0, 1);
      check("c_count", 72'(win_cnt), 72'(36));
      check("c_first", first_win, ramp_win(64, 0, 0));
      check("c_last", last_done_win, ramp_win(64, 5, 5));

      // Start-of-frame arriving on what would be pixel (5,4).
      clear_stats();
      for (int k = 0; k < 4*W + 5; k++) step(0, 1, k == 0, 8'(100 + k));
      check("d_abort_done", 72'(done_cnt), 72'(0));
      clear_stats();
      send_frame(32, 1, 1);
      check("d_count", 72'(win_cnt), 72'(36));
      check("d_done", 72'(done_cnt), 72'(1));
      check("d_first", first_win, ramp_win(32, 0, 0));

      // Reset while pixel (3,3) is presented, then restart without in_sof.
      clear_stats();
      for (int k = 0; k < 3*W + 3; k++) step(0, 1, k == 0, 8'($urandom));
      step(1, 1, 0, 8'h55);
      clear_stats();
      send_frame(16, 0, 0);
      check("e_latency", 72'(first_at), 72'(2*W + 3));
      check("e_count", 72'(win_cnt), 72'(36));
      check("e_first", first_win, ramp_win(16, 0, 0));

      // Random-valued frames with gaps.
      for (int f = 0; f < 3; f++) begin
         clear_stats();
         send_frame(-1, 1, 1);
         check("f_count", 72'(win_cnt), 72'(36));
         check("f_done", 72'(done_cnt), 72'(1));
      end

      step(0, 0, 0, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/window_reader.md
Name: window_reader

Overview:
- Read-side counterpart to the pixel line-delay chain: consumes a raster pixel stream and emits a 3x3 pixel window per accepted pixel once two full rows plus two columns are buffered.
- Owns two internal line memories and the x/y raster counters, so downstream filters (gradient, corner, blur) get a ready-made window with a valid strobe.
- No backpressure: the stream is push-only, like the line-delay chain.

Parameters:
- PIXEL_DEPTH, 8, bits per pixel.
- WIDTH, 8, pixels per line; must be >= 3.
- HEIGHT, 8, lines per frame; must be >= 3.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  in_pixel/in_sof valid this cycle.
- in_sof  input  1  start of frame; qualified by in_valid; forces this pixel to (0,0).
- in_pixel  input  PIXEL_DEPTH  raster-order pixel.
- out_valid  output  1  out_window valid, one-cycle pulse per window.
- out_window  output  9*PIXEL_DEPTH  3x3 window; tap (r,c) at bits [(r*3+c)*PIXEL_DEPTH +: PIXEL_DEPTH]; r=0 is the oldest row, c=0 is the oldest column.
- frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset: rst sampled high on a clk edge clears out_valid, out_window, frame_done, x, y, and the 3x3 tap registers to 0. Line memories are not reset.
- Accept: a pixel is accepted on any edge where in_valid=1. Pixel coordinates are (x,y), or (0,0) when in_sof=1.
- in_valid=0: all state holds, and out_valid and frame_done are 0 on the next cycle.
- Line memories: line0[x] holds row y-1, line1[x] holds row y-2.
- On accept: read line0[x] and line1[x] combinationally, then write line1[x]<=line0[x] and line0[x]<=in_pixel.
- Taps: columns shift left on accept. The new column c=2 is {r0=line1[x], r1=line0[x], r2=in_pixel}.
- Emit: out_valid=1 exactly one cycle after accepting pixel (x,y) with x>=2 and y>=2.
  - out_window then covers rows y-2..y and columns x-2..x; the window centre is (x-1,y-1).
  - Latency is 1 cycle.
  - The x>=2 condition guarantees no window mixes columns from adjacent lines.
- out_window updates on every accept, including non-emitting ones. It is only meaningful while out_valid=1.
- Counter advance:
  - x==WIDTH-1 wraps x to 0 and increments y.
  - x==WIDTH-1 with y==HEIGHT-1 wraps y to 0 and raises frame_done=1 the next cycle, together with out_valid for the final window.
- in_sof mid-frame: the counters restart at (0,0) for that pixel. Stale line contents are never emitted, because the next emit requires y>=2. There is no frame_done for the aborted frame.
- in_sof on the pixel that would already be (0,0): no effect beyond normal operation.
- Reset mid-frame: behaves as power-on. The first output after reset requires 2*WIDTH+3 accepts.
- Window count: exactly (WIDTH-2)*(HEIGHT-2) out_valid pulses per complete frame.

Optional Feature:
- Macro: WINDOW_READER_COORD_EN.
- When defined:
  - Adds ports out_x (output, $clog2(WIDTH)) and out_y (output, $clog2(HEIGHT)).
  - They carry the window centre (x-1,y-1), registered alongside out_valid.
  - Both reset to 0.
- When undefined: the ports and their registers are absent, and behaviour is otherwise identical.

Test Plan:
- Continuous frame, defaults, pixel=y*8+x, in_sof on the first pixel:
  - first out_valid is one cycle after accepting (2,2), with window {0,1,2,8,9,10,16,17,18};
  - last window is {45,46,47,53,54,55,61,62,63} with frame_done=1 in the same cycle;
  - exactly 36 out_valid pulses.
- Same frame with in_valid deasserted for random 1-5 cycle gaps: identical window sequence and count, no out_valid during gaps, each pulse lasts 1 cycle.
- Back-to-back frames with no idle cycle and in_sof on the second frame's first pixel (values +64): second-frame first window is {64,65,66,72,73,74,80,81,82}; no window contains first-frame data.
- in_sof asserted at (5,4) mid-frame, then a fresh frame: no frame_done for the aborted frame; 36 windows for the fresh frame.
- rst asserted for one cycle at (3,3):
  - all outputs are 0 the next cycle;
  - with a restarted frame, the first out_valid appears only after 19 accepts.
- With WINDOW_READER_COORD_EN: out_x/out_y step (1,1),(2,1)...(6,1),(1,2)...(6,6) across the 36 windows.
